// File: rtl/seg_scan_display.sv
// -----------------------------------------------------------------------------
// seg_scan_display
//
// Drives an 8-digit, common-anode, multiplexed seven-segment display. It shows
// the low 16 bits of two pipeline debug buses as two groups of four hex digits:
// NumberA on the left group (digits 7..4) and NumberB on the right group
// (digits 3..0).
//
// The two values are captured once per frame, at the last cycle of digit 7.
// A frame therefore never mixes old and new data. Hold freezes the display by
// skipping that capture. With BLANK_LZ=1, leading zeros within each group are
// dark. The least significant digit of each group always shows.
//
// Ports
//   Clk_in   in   1   system clock
//   Rst      in   1   asynchronous, active-high reset
//   NumberA  in  32   WB write data; bits [15:0] are shown on digits 7..4
//   NumberB  in  32   IF PC;         bits [15:0] are shown on digits 3..0
//   Hold     in   1   1 = keep the current frame values at the next wrap
//   out7     out  7   segments, active-low, {g,f,e,d,c,b,a}
//   en_out   out  8   digit anodes, active-low one-hot, [7] = leftmost
//
// Parameters
//   REFRESH_DIV  cycles each digit stays selected (>= 2)
//   BLANK_LZ     1 = blank leading zero digits within each 4-digit group
// -----------------------------------------------------------------------------
module seg_scan_display #(
   parameter int REFRESH_DIV = 100000,
   parameter int BLANK_LZ    = 0
) (
   input  logic        Clk_in,
   input  logic        Rst,
   input  logic [31:0] NumberA,
   input  logic [31:0] NumberB,
   input  logic        Hold,
   output logic [6:0]  out7,
   output logic [7:0]  en_out
);

   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] DIV_LAST = CW'(REFRESH_DIV - 1);

   logic [CW-1:0] div_cnt;
   logic [2:0]    dig_idx;
   logic [15:0]   latch_a;
   logic [15:0]   latch_b;

   // Only the low halves of the buses are displayed.
   logic unused_hi;
   assign unused_hi = ^{NumberA[31:16], NumberB[31:16]};

   logic slot_end;
   logic frame_end;
   assign slot_end  = (div_cnt == DIV_LAST);
   assign frame_end = slot_end && (dig_idx == 3'd7);

   // Active-low hex decode, {g,f,e,d,c,b,a}.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
      case (v)
         4'h0: hex_to_seg = 7'h40;
         4'h1: hex_to_seg = 7'h79;
         4'h2: hex_to_seg = 7'h24;
         4'h3: hex_to_seg = 7'h30;
         4'h4: hex_to_seg = 7'h19;
         4'h5: hex_to_seg = 7'h12;
         4'h6: hex_to_seg = 7'h02;
         4'h7: hex_to_seg = 7'h78;
         4'h8: hex_to_seg = 7'h00;
         4'h9: hex_to_seg = 7'h10;
         4'hA: hex_to_seg = 7'h08;
         4'hB: hex_to_seg = 7'h03;
         4'hC: hex_to_seg = 7'h46;
         4'hD: hex_to_seg = 7'h21;
         4'hE: hex_to_seg = 7'h06;
         default: hex_to_seg = 7'h0E;
      endcase
   endfunction

   // Select the nibble for the current digit. lead_zero is set when this
   // digit and every more-significant digit of its group are zero. The
   // lowest digit of a group (position 0) never counts as a leading zero.
   logic [15:0] grp;
   logic [3:0]  nib;
   logic        lead_zero;
   logic        blank;

   always_comb begin
      grp       = dig_idx[2] ? latch_a : latch_b;
      nib       = grp[3:0];
      lead_zero = 1'b0;
      case (dig_idx[1:0])
         2'd0: begin nib = grp[3:0];   lead_zero = 1'b0;                end
         2'd1: begin nib = grp[7:4];   lead_zero = (grp[15:4]  == '0); end
         2'd2: begin nib = grp[11:8];  lead_zero = (grp[15:8]  == '0); end
         default: begin nib = grp[15:12]; lead_zero = (grp[15:12] == '0); end
      endcase
      blank = (BLANK_LZ != 0) && lead_zero;
   end

   always_ff @(posedge Clk_in or posedge Rst) begin
      if (Rst) begin
         div_cnt <= '0;
         dig_idx <= 3'd0;
         latch_a <= 16'h0000;
         latch_b <= 16'h0000;
         out7    <= 7'h7F;
         en_out  <= 8'hFF;
      end else begin
         if (slot_end) begin
            div_cnt <= '0;
            dig_idx <= dig_idx + 3'd1;
         end else begin
            div_cnt <= div_cnt + CW'(1);
         end

         // Capture only at the frame boundary so a frame is never torn.
         if (frame_end && !Hold) begin
            latch_a <= NumberA[15:0];
            latch_b <= NumberB[15:0];
         end

         // Outputs follow the current digit and latches one cycle later.
         if (blank) begin
            out7   <= 7'h7F;
            en_out <= 8'hFF;
         end else begin
            out7   <= hex_to_seg(nib);
            en_out <= ~(8'b1 << dig_idx);
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_display.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_display
//
// Three instances share the stimulus:
//   u_d4   REFRESH_DIV=4, BLANK_LZ=0
//   u_b4   REFRESH_DIV=4, BLANK_LZ=1
//   u_d3   REFRESH_DIV=3, BLANK_LZ=0
// A reference model counts clock edges since reset release. It derives the
// digit from edge arithmetic and keeps the per-frame captured values. For
// every edge it pushes the expected {en_out,out7} into one queue per
// instance. A monitor on the falling edge pops the queues and compares.
// -----------------------------------------------------------------------------
module tb_seg_scan_display;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] num_a = '0;
   logic [31:0] num_b = '0;
   logic        hold = 1'b0;

   logic [6:0] seg_d4, seg_b4, seg_d3;
   logic [7:0] en_d4, en_b4, en_d3;

   int tests  = 0;
   int failed = 0;

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- DUTs ----------------
   seg_scan_display #(.REFRESH_DIV(4), .BLANK_LZ(0)) u_d4 (
      .Clk_in(clk), .Rst(rst), .NumberA(num_a), .NumberB(num_b),
      .Hold(hold), .out7(seg_d4), .en_out(en_d4));

   seg_scan_display #(.REFRESH_DIV(4), .BLANK_LZ(1)) u_b4 (
      .Clk_in(clk), .Rst(rst), .NumberA(num_a), .NumberB(num_b),
      .Hold(hold), .out7(seg_b4), .en_out(en_b4));

   seg_scan_display #(.REFRESH_DIV(3), .BLANK_LZ(0)) u_d3 (
      .Clk_in(clk), .Rst(rst), .NumberA(num_a), .NumberB(num_b),
      .Hold(hold), .out7(seg_d3), .en_out(en_d3));

   // ---------------- reference model ----------------
   logic [14:0] exp_q0[$];
   logic [14:0] exp_q1[$];
   logic [14:0] exp_q2[$];

   int          edges = 0;  // edges since reset release
   logic [15:0] fa[3];
   logic [15:0] fb[3];
   int          div_of[3]   = '{4, 4, 3};
   bit          blank_of[3] = '{1'b0, 1'b1, 1'b0};

   function automatic logic [6:0] seg_of(input int v);
      logic [6:0] tbl[16];
      tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      return tbl[v];
   endfunction

   // Expected {en_out,out7} after edge number n+1 since release.
   function automatic logic [14:0] model_out(input int dv, input bit bl,
                                             input logic [15:0] a,
                                             input logic [15:0] b,
                                             input int n);
      int d, p, grp, rest;
      d    = (n / dv) % 8;
      p    = d % 4;
      grp  = (d >= 4) ? int'(a) : int'(b);
      rest = grp >> (4 * p);
      if (bl && p != 0 && rest == 0)
         return {8'hFF, 7'h7F};
      return {~(8'd1 << d), seg_of(rest % 16)};
   endfunction

   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         logic [14:0] e;
         if (rst) begin
            fa[k] = '0;
            fb[k] = '0;
            e = {8'hFF, 7'h7F};
         end else begin
            e = model_out(div_of[k], blank_of[k], fa[k], fb[k], edges);
            if (((edges + 1) % (8 * div_of[k])) == 0 && !hold) begin
               fa[k] = num_a[15:0];
               fb[k] = num_b[15:0];
            end
         end
         case (k)
            0: exp_q0.push_back(e);
            1: exp_q1.push_back(e);
            default: exp_q2.push_back(e);
         endcase
      end
      if (rst) edges = 0;
      else     edges = edges + 1;
   end

   // ---------------- scoreboard monitor ----------------
   task automatic check(input string name, input logic [14:0] act,
                        input logic [14:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s t=%0t en_out/out7 got %h/%h expected %h/%h",
                  name, $time, act[14:7], act[6:0], exp[14:7], exp[6:0]);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q0.size() > 0) check("d4", {en_d4, seg_d4}, exp_q0.pop_front());
      if (exp_q1.size() > 0) check("b4", {en_b4, seg_b4}, exp_q1.pop_front());
      if (exp_q2.size() > 0) check("d3", {en_d3, seg_d3}, exp_q2.pop_front());
   end

   // ---------------- driver tasks ----------------
   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive(input logic [31:0] a, input logic [31:0] b,
                        input logic h);
      num_a = a;
      num_b = b;
      hold  = h;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int waited;
      logic [31:0] mask_a, mask_b;

      // Reset held, then released between edges.
      cycles(3);
      rst = 1'b0;

      // Values applied mid-frame 0 appear only from the next frame.
      cycles(10);
      drive(32'h0000_1234, 32'h0040_00AF, 1'b0);
      cycles(29);
      // Mid-frame change on the left group.
      drive(32'h0000_FFFF, 32'h0040_00AF, 1'b0);
      cycles(40);

      // Hold across a wrap, then release it.
      drive(32'h0000_FFFF, 32'h0000_BEEF, 1'b1);
      cycles(40);
      hold = 1'b0;
      cycles(40);

      // Leading-zero blanking case.
      drive(32'h0000_0007, 32'h0000_0000, 1'b0);
      cycles(70);

      // Randomized traffic, with masks so that small values (zeros) are common.
      for (int i = 0; i < 300; i++) begin
         mask_a = 32'hFFFF_FFFF >> ($urandom_range(0, 4) * 4 + 16);
         mask_b = 32'hFFFF_FFFF >> ($urandom_range(0, 4) * 4 + 16);
         if ($urandom_range(0, 3) == 0) mask_a = 32'hFFFF_FFFF;
         drive($urandom & mask_a, $urandom & mask_b,
               $urandom_range(0, 3) == 0);
         cycles($urandom_range(1, 12));
      end
      hold = 1'b0;

      // Async reset during the digit 5 slot of u_d4.
      waited = 0;
      while (en_d4 !== 8'hDF && waited < 64) begin
         cycles(1);
         waited++;
      end
      tests++;
      if (en_d4 !== 8'hDF) begin
         failed++;
         $display("FAIL digit5_wait en_out got %h expected df", en_d4);
      end
      #2;
      rst = 1'b1;
      exp_q0.delete();
      exp_q1.delete();
      exp_q2.delete();
      #1;
      check("async_rst_d4", {en_d4, seg_d4}, {8'hFF, 7'h7F});
      check("async_rst_b4", {en_b4, seg_b4}, {8'hFF, 7'h7F});
      check("async_rst_d3", {en_d3, seg_d3}, {8'hFF, 7'h7F});
      drive(32'h0000_5A3C, 32'h0000_0E10, 1'b0);
      cycles(2);
      rst = 1'b0;
      cycles(80);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
